// File: rtl/mem_copy_ctrl.sv
// -----------------------------------------------------------------------------
// mem_copy_ctrl
//
// Purpose:
//   Sequencer and arbiter in front of a single-port 8-bit x 256 data memory.
//   The memory has a combinational read and a write on the rising clock edge.
//   The memory port is shared between the CPU datapath and a byte copy/fill
//   engine. The CPU starts block copies (ascending, forward semantics on
//   overlap) and block fills. The CPU normally has priority. A starvation
//   counter forces an engine grant after STARVE_LIMIT consecutive denied
//   engine cycles, so the engine always makes forward progress.
//
// Parameters:
//   STARVE_LIMIT  consecutive denied engine cycles before a forced grant.
//                 0 disables forcing, so the CPU always wins. Range 0..255.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst_n        asynchronous, active-low reset
//   start        start request, sampled only in IDLE
//   mode         0 = copy, 1 = fill (captured at start)
//   src          copy source base address (captured at start)
//   dst          destination base address (captured at start)
//   len          byte count, 0 = no-op (captured at start)
//   fill_val     fill byte (captured at start)
//   busy         engine active (RD, WR or FILL)
//   done         one-cycle completion pulse
//   cpu_req      CPU needs the port this cycle
//   cpu_wr_en    CPU write enable
//   cpu_addr     CPU address
//   cpu_dat_in   CPU write data
//   cpu_stall    CPU denied this cycle (forced engine grant only)
//   mem_addr     memory address
//   mem_wr_en    memory write enable
//   mem_dat_in   memory write data
//   mem_dat_out  combinational memory read data (also wired straight to CPU)
// -----------------------------------------------------------------------------
module mem_copy_ctrl #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,

    // Engine command interface
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [7:0] len,
    input  logic [7:0] fill_val,
    output logic       busy,
    output logic       done,

    // CPU datapath side
    input  logic       cpu_req,
    input  logic       cpu_wr_en,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_dat_in,
    output logic       cpu_stall,

    // Memory port
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_dat_in,
    input  logic [7:0] mem_dat_out
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [7:0] STARVE_LIMIT_B = 8'(STARVE_LIMIT);
    localparam bit         FORCE_EN       = (STARVE_LIMIT != 0);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_FILL = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t     state_q,   state_d;
    logic [7:0] src_ptr_q, src_ptr_d;
    logic [7:0] dst_ptr_q, dst_ptr_d;
    logic [7:0] rem_q,     rem_d;
    logic [7:0] fill_q,    fill_d;
    logic [7:0] hold_q,    hold_d;
    logic [7:0] starve_q,  starve_d;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic eng_req;
    logic force_grant;
    logic eng_grant;

    // The engine wants the port in every working state; IDLE and DONE leave
    // the port to the CPU unconditionally.
    assign eng_req = (state_q == ST_RD) || (state_q == ST_WR) || (state_q == ST_FILL);

    // Forced grant only when the CPU is actually contending; an uncontended
    // engine wins anyway and must not raise cpu_stall.
    assign force_grant = FORCE_EN && eng_req && cpu_req && (starve_q == STARVE_LIMIT_B);

    assign eng_grant = eng_req && (!cpu_req || force_grant);

    assign cpu_stall = force_grant;

    // Status outputs come straight from the state register, so the
    // asynchronous reset clears them immediately.
    assign busy = eng_req;
    assign done = (state_q == ST_DONE);

    // -------------------------------------------------------------------------
    // Memory port mux
    // -------------------------------------------------------------------------
    // The CPU path is the default: whenever the engine is not granted, the
    // CPU signals pass through unchanged, including while in reset.
    always_comb begin
        mem_addr   = cpu_addr;
        mem_wr_en  = cpu_wr_en;
        mem_dat_in = cpu_dat_in;
        if (eng_grant) begin
            case (state_q)
                ST_RD: begin
                    mem_addr   = src_ptr_q;
                    mem_wr_en  = 1'b0;
                    mem_dat_in = hold_q;
                end
                ST_WR: begin
                    mem_addr   = dst_ptr_q;
                    mem_wr_en  = 1'b1;
                    mem_dat_in = hold_q;
                end
                ST_FILL: begin
                    mem_addr   = dst_ptr_q;
                    mem_wr_en  = 1'b1;
                    mem_dat_in = fill_q;
                end
                default: begin
                    mem_addr   = cpu_addr;
                    mem_wr_en  = cpu_wr_en;
                    mem_dat_in = cpu_dat_in;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Starvation counter
    // -------------------------------------------------------------------------
    // Counts consecutive denied engine cycles; any grant or any cycle without
    // an engine request restarts the count. With forcing enabled the count
    // never passes STARVE_LIMIT; with forcing disabled a wrap is harmless.
    always_comb begin
        starve_d = 8'd0;
        if (eng_req && !eng_grant) begin
            starve_d = starve_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // A denied engine state falls through every branch below, so pointers,
    // remaining count and hold register keep their values.
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        rem_d     = rem_q;
        fill_d    = fill_q;
        hold_d    = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_ptr_d = src;
                    dst_ptr_d = dst;
                    rem_d     = len;
                    fill_d    = fill_val;
                    if (len == 8'd0) begin
                        state_d = ST_DONE;
                    end else if (mode) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end

            ST_RD: begin
                if (eng_grant) begin
                    // Memory read is combinational, so the source byte is
                    // valid on mem_dat_out in this same cycle.
                    hold_d  = mem_dat_out;
                    state_d = ST_WR;
                end
            end

            ST_WR: begin
                if (eng_grant) begin
                    src_ptr_d = src_ptr_q + 8'd1;
                    dst_ptr_d = dst_ptr_q + 8'd1;
                    rem_d     = rem_q - 8'd1;
                    state_d   = (rem_q == 8'd1) ? ST_DONE : ST_RD;
                end
            end

            ST_FILL: begin
                if (eng_grant) begin
                    dst_ptr_d = dst_ptr_q + 8'd1;
                    rem_d     = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // start is deliberately not looked at here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            src_ptr_q <= 8'd0;
            dst_ptr_q <= 8'd0;
            rem_q     <= 8'd0;
            fill_q    <= 8'd0;
            hold_q    <= 8'd0;
            starve_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            rem_q     <= rem_d;
            fill_q    <= fill_d;
            hold_q    <= hold_d;
            starve_q  <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_ctrl
//
// Self-checking bench for mem_copy_ctrl. The bench owns the 8x256 memory
// (combinational read, write on the rising edge). A transaction-level model
// describes each operation as a list of engine steps (copy: read byte i then
// write byte i; fill: write byte i) and applies, cycle by cycle, either the
// next step or the CPU access according to the arbitration rules. Inputs are
// driven on the falling edge and outputs are compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_mem_copy_ctrl;

    localparam int LIMIT = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic [7:0] fill_val;
    logic       busy;
    logic       done;
    logic       cpu_req;
    logic       cpu_wr_en;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_dat_in;
    logic       cpu_stall;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_dat_in;
    logic [7:0] mem_dat_out;

    mem_copy_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .src         (src),
        .dst         (dst),
        .len         (len),
        .fill_val    (fill_val),
        .busy        (busy),
        .done        (done),
        .cpu_req     (cpu_req),
        .cpu_wr_en   (cpu_wr_en),
        .cpu_addr    (cpu_addr),
        .cpu_dat_in  (cpu_dat_in),
        .cpu_stall   (cpu_stall),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_dat_in  (mem_dat_in),
        .mem_dat_out (mem_dat_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-owned data memory
    logic [7:0] mem [256];
    assign mem_dat_out = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_dat_in;
    end

    // Counters
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] mdl_mem [256];
    int         mdl_phase;     // 0 idle, 1 working, 2 done pulse
    int         mdl_k;         // next engine step
    int         mdl_steps;     // total engine steps of the operation
    bit         mdl_mode;
    logic [7:0] mdl_src, mdl_dst, mdl_fill, mdl_hold;
    int         mdl_starve;

    // Values seen at the last compare point
    bit obs_busy, obs_done, obs_stall, obs_we;

    typedef struct {
        bit          m;
        logic [7:0]  s;
        logic [7:0]  d;
        logic [7:0]  l;
        logic [7:0]  f;
        bit          hold;
        int          exp_busy;
        int          exp_stall;
        logic [31:0] exp_mask;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic cpu_idle();
        cpu_req    = 1'b0;
        cpu_wr_en  = 1'b0;
        cpu_addr   = 8'h00;
        cpu_dat_in = 8'h00;
    endtask

    // One clock cycle: inputs already driven after a falling edge.
    task automatic tick();
        bit         req, forced, grant, e_we;
        logic [7:0] e_addr, e_din;
        #1;
        req    = (mdl_phase == 1);
        forced = req && cpu_req && (LIMIT != 0) && (mdl_starve == LIMIT);
        grant  = req && (!cpu_req || forced);
        e_we   = cpu_wr_en;
        e_addr = cpu_addr;
        e_din  = cpu_dat_in;
        if (grant) begin
            if (mdl_mode) begin
                e_addr = mdl_dst + 8'(mdl_k);
                e_we   = 1'b1;
                e_din  = mdl_fill;
            end else if (mdl_k % 2 == 0) begin
                e_addr = mdl_src + 8'(mdl_k / 2);
                e_we   = 1'b0;
            end else begin
                e_addr = mdl_dst + 8'(mdl_k / 2);
                e_we   = 1'b1;
                e_din  = mdl_hold;
            end
        end
        obs_busy  = busy;
        obs_done  = done;
        obs_stall = cpu_stall;
        obs_we    = mem_wr_en;
        chk("busy", busy, req);
        chk("done", done, mdl_phase == 2);
        chk("cpu_stall", cpu_stall, forced);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wr_en", mem_wr_en, e_we);
        if (e_we) chk("mem_dat_in", mem_dat_in, e_din);
        if (!grant && cpu_req && !cpu_wr_en) chk("cpu_rd_data", mem_dat_out, mdl_mem[cpu_addr]);

        if (grant && !mdl_mode && (mdl_k % 2 == 0)) mdl_hold = mdl_mem[e_addr];
        if (e_we) mdl_mem[e_addr] = e_din;
        if (grant) mdl_k++;
        mdl_starve = (req && !grant) ? mdl_starve + 1 : 0;
        case (mdl_phase)
            0: if (start) begin
                mdl_mode  = mode;
                mdl_src   = src;
                mdl_dst   = dst;
                mdl_fill  = fill_val;
                mdl_steps = mode ? int'(len) : 2 * int'(len);
                mdl_k     = 0;
                mdl_phase = (len == 8'd0) ? 2 : 1;
            end
            1: if (mdl_k == mdl_steps) mdl_phase = 2;
            default: mdl_phase = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 256; a++) chk($sformatf("%s mem[%0d]", tag, a), mem[a], mdl_mem[a]);
    endtask

    task automatic run_op(input bit m, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] f, input bit hold,
                          output int busy_n, output int stall_n,
                          output logic [31:0] mask, output int done_at);
        busy_n = 0; stall_n = 0; mask = 32'd0; done_at = 0;
        start = 1'b1; mode = m; src = s; dst = d; len = l; fill_val = f;
        cpu_idle();
        tick();
        start = 1'b0;
        for (int c = 1; c <= 600 && done_at == 0; c++) begin
            if (hold) begin
                cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 8'hF0;
            end else begin
                cpu_idle();
            end
            tick();
            if (obs_busy)  busy_n++;
            if (obs_stall) stall_n++;
            if (obs_we && c < 32) mask[c] = 1'b1;
            if (obs_done) done_at = c;
        end
        cpu_idle();
    endtask

    initial begin
        int          b_n, s_n, d_at, dcnt;
        logic [31:0] msk;
        logic [7:0]  orig [4];
        bit          seen;

        vecs[0] = '{1'b0, 8'd60,  8'd100, 8'd3,  8'h00, 1'b0, 6,  0, 32'h0000_0054};
        vecs[1] = '{1'b1, 8'd0,   8'd254, 8'd3,  8'hA5, 1'b0, 3,  0, 32'h0000_000E};
        vecs[2] = '{1'b0, 8'd5,   8'd200, 8'd0,  8'h00, 1'b0, 0,  0, 32'h0000_0000};
        vecs[3] = '{1'b0, 8'd30,  8'd40,  8'd1,  8'h00, 1'b1, 10, 2, 32'h0000_0400};
        vecs[4] = '{1'b1, 8'd0,   8'd120, 8'd2,  8'h5A, 1'b1, 10, 2, 32'h0000_0420};
        vecs[5] = '{1'b0, 8'd250, 8'd3,   8'd10, 8'h00, 1'b0, 20, 0, 32'h0015_5554};
        vecs[6] = '{1'b0, 8'd10,  8'd11,  8'd4,  8'h00, 1'b0, 8,  0, 32'h0000_0154};

        for (int a = 0; a < 256; a++) mdl_mem[a] = 8'h00;
        mdl_phase = 0; mdl_k = 0; mdl_steps = 0; mdl_starve = 0;
        mdl_mode = 1'b0; mdl_src = 8'h00; mdl_dst = 8'h00; mdl_fill = 8'h00; mdl_hold = 8'h00;

        // Reset state: CPU path through the mux, engine idle
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = 8'h00; dst = 8'h00;
        len = 8'h00; fill_val = 8'h00;
        cpu_req = 1'b0; cpu_wr_en = 1'b0; cpu_addr = 8'h3C; cpu_dat_in = 8'h99;
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset cpu_stall", cpu_stall, 1'b0);
        chk("reset mem_addr", mem_addr, 8'h3C);
        chk("reset mem_wr_en", mem_wr_en, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload the whole memory through the CPU path
        for (int a = 0; a < 256; a++) begin
            cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 8'(a);
            cpu_dat_in = (a == 60) ? 8'h10 : (a == 61) ? 8'hE0 : (a == 62) ? 8'hF0 : 8'(a * 37 + 11);
            tick();
        end
        cpu_idle();
        tick();

        // Table-driven operations
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].m, vecs[i].s, vecs[i].d, vecs[i].l, vecs[i].f, vecs[i].hold,
                   b_n, s_n, msk, d_at);
            chk($sformatf("vec%0d busy_cycles", i), b_n, vecs[i].exp_busy);
            chk($sformatf("vec%0d done_cycle", i), d_at, vecs[i].exp_busy + 1);
            chk($sformatf("vec%0d stall_cycles", i), s_n, vecs[i].exp_stall);
            chk($sformatf("vec%0d we_cycles", i), msk, vecs[i].exp_mask);
            if (i == 0) begin
                chk("copy mem[100]", mem[100], 8'h10);
                chk("copy mem[101]", mem[101], 8'hE0);
                chk("copy mem[102]", mem[102], 8'hF0);
            end
            if (i == 1) begin
                chk("fill mem[254]", mem[254], 8'hA5);
                chk("fill mem[255]", mem[255], 8'hA5);
                chk("fill mem[0]",   mem[0],   8'hA5);
            end
            sweep($sformatf("vec%0d", i));
            tick();
        end

        // Start while busy: second start ignored, single done pulse
        for (int i = 0; i < 4; i++) orig[i] = mdl_mem[70 + i];
        start = 1'b1; mode = 1'b0; src = 8'd70; dst = 8'd150; len = 8'd4; fill_val = 8'h00;
        tick();
        dcnt = 0; b_n = 0;
        for (int c = 1; c <= 40; c++) begin
            start = (c == 3);
            if (c == 3) begin
                mode = 1'b1; src = 8'd0; dst = 8'd1; len = 8'd2; fill_val = 8'h77;
            end
            tick();
            if (obs_done) dcnt++;
            if (obs_busy) b_n++;
        end
        start = 1'b0;
        chk("busy_start done_pulses", dcnt, 1);
        chk("busy_start busy_cycles", b_n, 8);
        for (int i = 0; i < 4; i++) chk($sformatf("busy_start mem[%0d]", 150 + i), mem[150 + i], orig[i]);

        // Reset during the write of byte 2 of a 4-byte copy
        orig[0] = mdl_mem[80];
        for (int i = 1; i < 4; i++) orig[i] = mdl_mem[160 + i];
        start = 1'b1; mode = 1'b0; src = 8'd80; dst = 8'd160; len = 8'd4;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) tick();
        #1;
        chk("rst_mid busy_before", busy, 1'b1);
        chk("rst_mid we_before", mem_wr_en, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid busy", busy, 1'b0);
        chk("rst_mid done", done, 1'b0);
        chk("rst_mid mem_wr_en", mem_wr_en, 1'b0);
        chk("rst_mid cpu_stall", cpu_stall, 1'b0);
        mdl_phase = 0; mdl_k = 0; mdl_starve = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_mid mem[160]", mem[160], orig[0]);
        for (int i = 1; i < 4; i++) chk($sformatf("rst_mid mem[%0d]", 160 + i), mem[160 + i], orig[i]);
        run_op(1'b1, 8'd0, 8'd90, 8'd2, 8'h33, 1'b0, b_n, s_n, msk, d_at);
        chk("after_rst busy_cycles", b_n, 2);
        chk("after_rst done_cycle", d_at, 3);
        chk("after_rst we_cycles", msk, 32'h0000_0006);
        sweep("after_rst");

        // Randomized operations with random CPU traffic
        for (int r = 0; r < 40; r++) begin
            start = 1'b1;
            mode = 1'($urandom_range(0, 1));
            src = 8'($urandom); dst = 8'($urandom); fill_val = 8'($urandom);
            len = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
            cpu_idle();
            tick();
            seen = 1'b0;
            for (int c = 1; c <= 3000 && !seen; c++) begin
                cpu_req    = ($urandom_range(0, 2) == 0);
                cpu_wr_en  = cpu_req && ($urandom_range(0, 1) == 1);
                cpu_addr   = 8'($urandom);
                cpu_dat_in = 8'($urandom);
                start      = (mdl_phase == 1) && ($urandom_range(0, 7) == 0);
                mode = 1'($urandom_range(0, 1));
                src = 8'($urandom); dst = 8'($urandom); len = 8'($urandom_range(1, 9));
                tick();
                if (obs_done) seen = 1'b1;
            end
            start = 1'b0;
            cpu_idle();
            chk($sformatf("rand%0d done_seen", r), seen, 1'b1);
            tick();
        end
        sweep("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
